// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the drop_out_fifo reader: FSM states, skid depth and the
// width rule for the burst position counter.
package fifo_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;

   // A one-word burst still needs a one-bit counter so the compare logic stays uniform.
   function automatic int burst_cnt_width(input int burst_len);
      return (burst_len <= 1) ? 1 : $clog2(burst_len);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry registered skid buffer. Slot0 is always the head, so the output word comes
// straight from a register and stays put while the consumer stalls.
module stream_skid_buf
   import fifo_stream_pkg::*;
#(
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        occ,
   output logic [DWIDTH-1:0] head_data
);

   localparam logic [1:0] FULL = 2'(SKID_DEPTH);

   logic [DWIDTH-1:0] slot0;
   logic [DWIDTH-1:0] slot1;
   logic              push_ok;
   logic              pop_ok;

   assign pop_ok    = pop && (occ != 2'd0);
   assign push_ok   = push && ((occ != FULL) || pop_ok);
   assign head_data = slot0;

   // A simultaneous push and pop keeps the occupancy and shifts the queue by one slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ   <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (occ == 2'd0) begin
                  slot0 <= push_data;
               end else begin
                  slot1 <= push_data;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == FULL) begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end else begin
                  slot0 <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reader-side controller for drop_out_fifo: pops words, absorbs the registered read latency
// in a skid buffer and presents them as a burst-framed valid/ready stream.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int BURST_LEN = 4,
   parameter int CWIDTH    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty_flg,
   input  logic [DWIDTH-1:0] fifo_rdata,
   output logic              fifo_read_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic [CWIDTH-1:0] word_cnt
);

   localparam int             BCW      = burst_cnt_width(BURST_LEN);
   localparam logic [BCW-1:0] LAST_CNT = BCW'(BURST_LEN - 1);

   state_t            state;
   state_t            state_nxt;
   logic              inflight;
   logic              take;
   logic              pending;
   logic [1:0]        occ;
   logic [1:0]        pend_after_take;
   logic [DWIDTH-1:0] head_data;
   logic [BCW-1:0]    burst_cnt;

   stream_skid_buf #(
      .DWIDTH(DWIDTH)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight),
      .push_data(fifo_rdata),
      .pop      (take),
      .occ      (occ),
      .head_data(head_data)
   );

   assign out_valid = (occ != 2'd0);
   assign out_data  = head_data;
   assign out_last  = out_valid && (burst_cnt == LAST_CNT);
   assign take      = out_valid && out_ready;
   assign busy      = (state != IDLE);
   assign pending   = (occ != 2'd0) || inflight;

   // Buffered plus in-flight words, less the one leaving this cycle, must leave room for
   // the word a new read would return next cycle.
   assign pend_after_take = occ + {1'b0, inflight} - {1'b0, take};
   assign fifo_read_en    = !rst && (state == RUN) && !fifo_empty_flg
                            && (pend_after_take < 2'd2);

   // Next-state logic; DRAIN lets already-popped words leave before going IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               state_nxt = pending ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (en) begin
               state_nxt = RUN;
            end else if (!pending) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Clearing inflight on reset drops the word the FIFO returns right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_read_en;
      end
   end

   // Burst position survives en toggling; only reset realigns the framing.
   always_ff @(posedge clk) begin
      if (rst) begin
         burst_cnt <= '0;
      end else if (take) begin
         if (burst_cnt == LAST_CNT) begin
            burst_cnt <= '0;
         end else begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt <= '0;
      end else if (take && (word_cnt != '1)) begin
         word_cnt <= word_cnt + 1'b1;
      end
   end

endmodule
